// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, 1-cycle-latency imem reads, prefetch FIFO, redirect flush.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
module fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INST_W   = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [15:0]       stat_flushes,
  output logic [31:0]       stat_stalls
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              out_q, out_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic issue;
  logic head_valid;
  logic push;
  logic pop;
  logic unused_rpc_lsbs;

  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  // Credit check counts the in-flight read so its response always has a free slot.
  always_comb begin
    issue      = 1'b0;
    head_valid = (cnt_q != '0);
    push       = 1'b0;
    pop        = 1'b0;
    if (!reset) begin
      issue = (state_q == RUN) && !redirect &&
              ((cnt_q + CNT_W'(out_q)) < CNT_W'(DEPTH));
      push  = imem_rvalid && (state_q != FLUSH) && !redirect;
      pop   = head_valid && !redirect && inst_ready;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    out_d    = issue;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;

    if (redirect) begin
      state_d = FLUSH;
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = RUN;
        RUN:     if (!enable) state_d = IDLE;
        FLUSH:   state_d = enable ? RUN : IDLE;
        default: state_d = IDLE;
      endcase

      if (issue) begin
        pc_d     = pc_q + ADDR_W'(4);
        req_pc_d = pc_q;
      end

      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      out_q    <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      out_q    <= out_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only exposed while the FIFO is non-empty.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem_q[wr_q] <= imem_rdata;
      pc_mem_q[wr_q]   <= req_pc_q;
    end
  end

  assign imem_req   = issue;
  assign imem_addr  = pc_q;
  assign inst_valid = head_valid && !redirect && !reset;
  assign inst       = inst_valid ? inst_mem_q[rd_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem_q[rd_q]   : '0;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && (cnt_q == CNT_W'(DEPTH)) && !pop));

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q;
  logic [15:0] flushes_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_q <= '0;
      flushes_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (pop)                     fetched_q <= fetched_q + 32'd1;
      if (redirect)                flushes_q <= flushes_q + 16'd1;
      if (inst_valid && !inst_ready) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushes = flushes_q;
  assign stat_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a 1-cycle-latency instruction memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [15:0] stat_flushes;
  logic [31:0] stat_stalls;
`endif

  logic        mv_q = 1'b0;
  logic [31:0] md_q = '0;
  logic        inj  = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushes(stat_flushes),
    .stat_stalls (stat_stalls)
`endif
  );

  always #5 clock = ~clock;

  // Memory returns word index (addr>>2); inj forces a spurious response.
  always @(posedge clock) begin
    mv_q <= imem_req;
    md_q <= imem_addr >> 2;
  end
  assign imem_rvalid = mv_q | inj;
  assign imem_rdata  = inj ? 32'hDEADBEEF : md_q;

  typedef struct {
    logic        en, rdy, redir, inj, rst, chk;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst, ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic en, logic rdy, logic redir, logic [31:0] rpc,
                              logic vinj, logic rst, logic chk, logic req,
                              logic [31:0] addr, logic vld, logic [31:0] ins,
                              logic [31:0] ipc);
    vec_t v;
    v.en = en; v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.inj = vinj;
    v.rst = rst; v.chk = chk; v.req = req; v.addr = addr; v.vld = vld;
    v.inst = ins; v.ipc = ipc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int          drained;
    logic [31:0] exp_pc;

    // en rdy redir rpc vinj rst chk | req addr vld inst ipc
    // Test 1: stream from reset
    add(1,1,0,0,0,0,1, 0,32'd0 ,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'd0 ,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'd4 ,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'd8 ,1,0,0);
    add(1,1,0,0,0,0,1, 1,32'd12,1,1,4);
    add(1,1,0,0,0,0,1, 1,32'd16,1,2,8);
    // Test 2: backpressure fills the FIFO, then resumes in order
    add(1,0,0,0,0,0,1, 1,32'd20,1,3,12);
    add(1,0,0,0,0,0,1, 1,32'd24,1,3,12);
    for (int k = 0; k < 8; k++) add(1,0,0,0,0,0,1, 0,32'd28,1,3,12);
    add(1,1,0,0,0,0,1, 0,32'd28,1,3,12);
    add(1,1,0,0,0,0,1, 1,32'd28,1,4,16);
    add(1,1,0,0,0,0,1, 1,32'd32,1,5,20);
    add(1,1,0,0,0,0,1, 1,32'd36,1,6,24);
    add(1,1,0,0,0,0,1, 1,32'd40,1,7,28);
    add(1,1,0,0,0,0,1, 1,32'd44,1,8,32);
    // Test 3: redirect with 3 entries queued and one read in flight
    add(1,0,0,0,0,0,1, 1,32'd48,1,9,36);
    add(1,0,1,32'h100,0,0,1, 0,32'd52,0,0,0);
    add(1,1,0,0,1,0,1, 0,32'h100,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'h100,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'h104,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'h108,1,32'h40,32'h100);
    // Test 4: unaligned target, redirect collides with a pop
    add(1,1,1,32'h203,0,0,1, 0,32'h10C,0,0,0);
    add(1,1,0,0,0,0,1, 0,32'h200,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'h200,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'h204,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'h208,1,32'h80,32'h200);
    // Test 5: PC wrap at the top of the address space
    add(1,1,1,32'hFFFFFFF8,0,0,1, 0,32'h20C,0,0,0);
    add(1,1,0,0,0,0,1, 0,32'hFFFFFFF8,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'hFFFFFFF8,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'hFFFFFFFC,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'h0,1,32'h3FFFFFFE,32'hFFFFFFF8);
    add(1,1,0,0,0,0,1, 1,32'h4,1,32'h3FFFFFFF,32'hFFFFFFFC);
    add(1,1,0,0,0,0,1, 1,32'h8,1,32'h0,32'h0);
    // Test 6: reset mid-stream with a read in flight
    add(1,1,0,0,0,1,0, 0,0,0,0,0);
    add(1,1,0,0,0,0,1, 0,32'd0,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'd0,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'd4,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'd8,1,0,0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset imem_req",   {31'b0, imem_req},   32'd0);
    chk("reset imem_addr",  imem_addr,           32'd0);
    chk("reset inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("reset inst",       inst,                32'd0);
    chk("reset inst_pc",    inst_pc,             32'd0);
`ifdef FETCH_STATS_EN
    chk("reset stat_fetched", stat_fetched, 32'd0);
    chk("reset stat_flushes", {16'b0, stat_flushes}, 32'd0);
    chk("reset stat_stalls",  stat_stalls,  32'd0);
`endif
    @(posedge clock); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      enable      = vecs[i].en;
      inst_ready  = vecs[i].rdy;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      inj         = vecs[i].inj;
      reset       = vecs[i].rst;
      @(negedge clock);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d imem_req", i),   {31'b0, imem_req},   {31'b0, vecs[i].req});
        chk($sformatf("v%0d imem_addr", i),  imem_addr,           vecs[i].addr);
        chk($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].vld});
        chk($sformatf("v%0d inst", i),       inst,                vecs[i].inst);
        chk($sformatf("v%0d inst_pc", i),    inst_pc,             vecs[i].ipc);
      end
`ifdef FETCH_STATS_EN
      if (i == 28) begin
        chk("stats after test3 fetched", stat_fetched, 32'd10);
        chk("stats after test3 flushes", {16'b0, stat_flushes}, 32'd1);
        chk("stats after test3 stalls",  stat_stalls, 32'd11);
      end
      if (i == 29) begin
        chk("stats redirect-pop fetched", stat_fetched, 32'd10);
        chk("stats redirect-pop flushes", {16'b0, stat_flushes}, 32'd2);
      end
`endif
      @(posedge clock); #1;
    end

    // enable drops mid-stream: one last issue from RUN, then the FIFO drains.
    enable = 1'b0; inst_ready = 1'b0; redirect = 1'b0; inj = 1'b0; reset = 1'b0;
    @(negedge clock);
    chk("disable last req",  {31'b0, imem_req}, 32'd1);
    chk("disable last addr", imem_addr, 32'd12);
    @(posedge clock); #1;
    @(negedge clock);
    chk("idle no req",     {31'b0, imem_req},   32'd0);
    chk("idle head valid", {31'b0, inst_valid}, 32'd1);
    chk("idle head pc",    inst_pc,             32'd4);
    @(posedge clock); #1;
    inst_ready = 1'b1;
    drained = 0;
    exp_pc  = 32'd4;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk($sformatf("drain%0d no req", k), {31'b0, imem_req}, 32'd0);
      if (inst_valid) begin
        chk($sformatf("drain%0d inst_pc", k), inst_pc, exp_pc);
        chk($sformatf("drain%0d inst", k),    inst,    exp_pc >> 2);
        exp_pc  = exp_pc + 32'd4;
        drained++;
      end
      @(posedge clock); #1;
    end
    chk("drain count", drained, 32'd3);
    chk("drained empty", {31'b0, inst_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
